// File: rtl/seg_bus_reader_if.sv
// Seven-segment display bus plus decoded readback, shared between display
// side (master) and the seg_bus_reader observer (slave).
interface seg_bus_reader_if;
    logic [7:0]  seven_seg_n;
    logic [3:0]  anode_n;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  dp;
    logic        update;
    logic [1:0]  update_idx;
    logic        decode_err;

    modport master (
        output seven_seg_n, anode_n,
        input  digits, digit_valid, dp, update, update_idx, decode_err
    );

    modport slave (
        input  seven_seg_n, anode_n,
        output digits, digit_valid, dp, update, update_idx, decode_err
    );
endinterface

// File: rtl/seg_bus_reader.sv
// Observer for a multiplexed active-low seven-segment bus: waits for each
// anode dwell to settle, then decodes segments back to hex digit and dp.
module seg_bus_reader #(
    parameter int SETTLE_CYCLES = 16,
    parameter int STALE_CYCLES  = 65536
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_bus_reader_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(STALE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] STALE_MAX  = TW'(STALE_CYCLES);
    localparam logic [TW-1:0] STALE_LAST = TW'(STALE_CYCLES - 1);

    // {ok, value}; ok=0 for any pattern outside the hex font, blank included
    function automatic logic [4:0] decode7(input logic [6:0] raw);
        case (raw)
            7'h3F: return {1'b1, 4'h0};
            7'h06: return {1'b1, 4'h1};
            7'h5B: return {1'b1, 4'h2};
            7'h4F: return {1'b1, 4'h3};
            7'h66: return {1'b1, 4'h4};
            7'h6D: return {1'b1, 4'h5};
            7'h7D: return {1'b1, 4'h6};
            7'h07: return {1'b1, 4'h7};
            7'h7F: return {1'b1, 4'h8};
            7'h6F: return {1'b1, 4'h9};
            7'h77: return {1'b1, 4'hA};
            7'h7C: return {1'b1, 4'hB};
            7'h39: return {1'b1, 4'hC};
            7'h5E: return {1'b1, 4'hD};
            7'h79: return {1'b1, 4'hE};
            7'h71: return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    logic [11:0]   sync1_q, sync2_q, prev_q;
    logic [SW-1:0] stable_cnt_q;
    state_t        state_q, state_d;
    logic [TW-1:0] stale_cnt_q [4];

    logic [15:0] digits_q;
    logic [3:0]  valid_q, dp_q;
    logic        update_q, err_q;
    logic [1:0]  idx_q;

    logic        changed, one_hot, settled, capture;
    logic [3:0]  cap_sel;
    logic [1:0]  cap_pos;
    logic [4:0]  dec;

    assign changed = (sync2_q != prev_q);
    assign one_hot = $onehot(~sync2_q[11:8]);
    assign settled = (stable_cnt_q == SETTLE_MAX);

    // Bus sampling: 2-flop synchronizer, previous sample, stability counter.
    // Reset to all-ones so the first real bus value always looks like a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            prev_q       <= '1;
            stable_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            sync1_q <= {bus.anode_n, bus.seven_seg_n};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (changed)
                stable_cnt_q <= '0;
            else if (!settled)
                stable_cnt_q <= stable_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        case (state_q)
            IDLE:    if (one_hot) state_d = SETTLE;
            SETTLE: begin
                if (changed)      state_d = one_hot ? SETTLE : IDLE;
                else if (settled) state_d = HELD;
            end
            HELD:    if (changed) state_d = one_hot ? SETTLE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        capture = (state_q == SETTLE) && !changed && settled && one_hot;
        cap_sel = capture ? ~sync2_q[11:8] : 4'b0000;
        dec     = decode7(~sync2_q[6:0]);
        cap_pos = 2'd0;
        case (sync2_q[11:8])
            4'b1101: cap_pos = 2'd1;
            4'b1011: cap_pos = 2'd2;
            4'b0111: cap_pos = 2'd3;
            default: cap_pos = 2'd0;
        endcase
    end

    // Per-position capture and staleness; a capture on a position overrides
    // its stale expiry in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            valid_q  <= '0;
            dp_q     <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            // NOTE: the small per-position counter array is flops, so it is reset explicitly.
            for (int i = 0; i < 4; i++) stale_cnt_q[i] <= '0;
        end else begin
            update_q <= capture;
            err_q    <= capture && !dec[4];
            if (capture) idx_q <= cap_pos;
            for (int i = 0; i < 4; i++) begin
                if (cap_sel[i]) begin
                    stale_cnt_q[i] <= '0;
                    dp_q[i]        <= ~sync2_q[7];
                    valid_q[i]     <= dec[4];
                    if (dec[4]) digits_q[4*i +: 4] <= dec[3:0];
                end else if (stale_cnt_q[i] != STALE_MAX) begin
                    stale_cnt_q[i] <= stale_cnt_q[i] + TW'(1);
                    if (stale_cnt_q[i] == STALE_LAST) valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.dp          = dp_q;
    assign bus.update      = update_q;
    assign bus.update_idx  = idx_q;
    assign bus.decode_err  = err_q;

endmodule

// File: tb/tb_seg_bus_reader.sv
// Self-checking bench for seg_bus_reader: directed scenarios plus a random
// dwell phase, all compared cycle by cycle against a run-length bus model.
module tb_seg_bus_reader;

    localparam int SETTLE = 16;
    localparam int STALE  = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_bus_reader_if bus ();

    seg_bus_reader #(.SETTLE_CYCLES(SETTLE), .STALE_CYCLES(STALE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int upd_seen = 0;
    int err_seen = 0;

    // Reference model: bus history, run length of the sample two edges back, ages
    logic [11:0] m_hist [$];
    int          m_run;
    int          m_age [4];
    logic [15:0] m_digits;
    logic [3:0]  m_valid, m_dp;
    logic        m_update, m_err;
    logic [1:0]  m_idx;

    function automatic logic [7:0] mkseg(input logic [6:0] raw, input logic dp_on);
        return {~dp_on, ~raw};
    endfunction

    function automatic logic [3:0] an_of(input int p);
        return ~(4'b0001 << p);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        repeat (3) m_hist.push_back(12'hFFF);
        m_run    = 1000;
        m_digits = '0;
        m_valid  = '0;
        m_dp     = '0;
        m_update = 1'b0;
        m_err    = 1'b0;
        m_idx    = '0;
        for (int i = 0; i < 4; i++) m_age[i] = 0;
    endtask

    // A bus value is captured once it has been seen unchanged for SETTLE+2
    // consecutive edges; its effect shows three edges after it first appeared.
    task automatic model_edge(input logic [11:0] v);
        logic [11:0] x;
        logic [6:0]  raw;
        logic        cap;
        int          pos;
        int          found;
        m_hist.push_back(v);
        while (m_hist.size() > 4) void'(m_hist.pop_front());
        x = m_hist[1];
        if (x == m_hist[0]) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        cap = (m_run == SETTLE + 2) && ($countones(~x[11:8]) == 1);
        pos = 0;
        for (int i = 0; i < 4; i++) if (!x[8+i]) pos = i;
        m_update = cap;
        m_err    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cap && i == pos) begin
                m_age[i] = 0;
                raw   = ~x[6:0];
                found = -1;
                for (int d = 0; d < 16; d++) if (seg_tab[d] == raw) found = d;
                m_dp[i] = ~x[7];
                if (found >= 0) begin
                    m_digits[4*i +: 4] = 4'(found);
                    m_valid[i] = 1'b1;
                end else begin
                    m_valid[i] = 1'b0;
                    m_err = 1'b1;
                end
                m_idx = 2'(i);
            end else begin
                if (m_age[i] < STALE) m_age[i]++;
                if (m_age[i] >= STALE) m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("update", 32'(bus.update), 32'(m_update));
        check("decode_err", 32'(bus.decode_err), 32'(m_err));
        check("digits", 32'(bus.digits), 32'(m_digits));
        check("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
        check("dp", 32'(bus.dp), 32'(m_dp));
        if (m_update) check("update_idx", 32'(bus.update_idx), 32'(m_idx));
    endtask

    // Drive away from the edge, advance one edge, model it, sample 1 time unit later
    task automatic tick(input logic [7:0] seg, input logic [3:0] an);
        bus.seven_seg_n = seg;
        bus.anode_n     = an;
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge({an, seg});
        else       model_reset();
        #1;
        if (bus.update === 1'b1)     upd_seen++;
        if (bus.decode_err === 1'b1) err_seen++;
        compare_all();
    endtask

    task automatic dwell(input logic [7:0] seg, input logic [3:0] an, input int n);
        repeat (n) tick(seg, an);
    endtask

    task automatic gap(input int n);
        dwell(8'hFF, 4'hF, n);
    endtask

    int cap;
    int rp;
    logic [6:0] rraw;
    logic [3:0] ran;
    logic [7:0] rseg;

    initial begin
        bus.seven_seg_n = 8'hFF;
        bus.anode_n     = 4'hF;
        model_reset();

        // Reset state
        gap(4);
        check("reset_digits", 32'(bus.digits), 32'h0);
        check("reset_update", 32'(bus.update), 32'h0);
        rst_n = 1'b1;
        gap(3);

        // Single capture of "3" on position 0: update only in cycle SETTLE+3
        for (int k = 0; k < 25; k++) begin
            tick(mkseg(7'h4F, 1'b0), 4'b1110);
            check("single_update", 32'(bus.update), 32'(k == SETTLE + 3));
            if (k == SETTLE + 3) begin
                check("single_idx", 32'(bus.update_idx), 32'd0);
                check("single_digit", 32'(bus.digits[3:0]), 32'h3);
                check("single_valid", 32'(bus.digit_valid), 32'b0001);
                check("single_dp", 32'(bus.dp), 32'b0000);
            end
        end
        gap(2);

        // Scan 1,2,A,F with dp on position 2, 40-cycle dwells, 2-cycle gaps
        for (int p = 0; p < 4; p++) begin
            upd_seen = 0;
            case (p)
                0: dwell(mkseg(7'h06, 1'b0), an_of(0), 40);
                1: dwell(mkseg(7'h5B, 1'b0), an_of(1), 40);
                2: dwell(mkseg(7'h77, 1'b1), an_of(2), 40);
                default: dwell(mkseg(7'h71, 1'b0), an_of(3), 40);
            endcase
            check("scan_one_update", upd_seen, 1);
            gap(2);
        end
        check("scan_digits", 32'(bus.digits), 32'hFA21);
        check("scan_valid", 32'(bus.digit_valid), 32'b1111);
        check("scan_dp", 32'(bus.dp), 32'b0100);

        // Blank and non-font patterns on position 1
        for (int b = 0; b < 2; b++) begin
            upd_seen = 0;
            err_seen = 0;
            dwell(mkseg((b == 0) ? 7'h00 : 7'h7E, 1'b0), an_of(1), 25);
            check("invalid_update", upd_seen, 1);
            check("invalid_err", err_seen, 1);
            check("invalid_valid1", 32'(bus.digit_valid[1]), 32'h0);
            check("invalid_keep", 32'(bus.digits[7:4]), 32'h2);
            gap(2);
        end

        // Short dwell: no capture
        upd_seen = 0;
        dwell(mkseg(7'h6D, 1'b0), an_of(2), 10);
        gap(2);
        check("short_dwell", upd_seen, 0);

        // 3-cycle segment glitch inside a 60-cycle dwell: two captures, same value
        upd_seen = 0;
        dwell(mkseg(7'h6D, 1'b0), an_of(2), 25);
        dwell(mkseg(7'h6C, 1'b0), an_of(2), 3);
        dwell(mkseg(7'h6D, 1'b0), an_of(2), 32);
        check("glitch_updates", upd_seen, 2);
        check("glitch_digit", 32'(bus.digits[11:8]), 32'h5);
        check("glitch_valid", 32'(bus.digit_valid[2]), 32'h1);
        gap(2);

        // Reset mid-settle, then a full settle before the next update
        dwell(mkseg(7'h07, 1'b0), an_of(3), 8);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_digits", 32'(bus.digits), 32'h0);
        check("rst_valid", 32'(bus.digit_valid), 32'h0);
        check("rst_dp", 32'(bus.dp), 32'h0);
        check("rst_update", 32'(bus.update), 32'h0);
        check("rst_idx", 32'(bus.update_idx), 32'h0);
        check("rst_err", 32'(bus.decode_err), 32'h0);
        dwell(mkseg(7'h07, 1'b0), an_of(3), 3);
        rst_n = 1'b1;
        for (int k = 0; k < 23; k++) begin
            tick(mkseg(7'h07, 1'b0), an_of(3));
            check("post_rst_update", 32'(bus.update), 32'(k == SETTLE + 3));
        end
        gap(3);

        // Staleness: position 3 expires STALE cycles after its capture
        cap = cyc + 1 + SETTLE + 3;
        dwell(mkseg(7'h6F, 1'b0), an_of(3), 25);
        while (cyc < cap + STALE - 1) tick(mkseg(7'h66, 1'b0), an_of(0));
        check("stale_before", 32'(bus.digit_valid[3]), 32'h1);
        tick(mkseg(7'h66, 1'b0), an_of(0));
        check("stale_clear", 32'(bus.digit_valid[3]), 32'h0);
        check("stale_hold", 32'(bus.digits[15:12]), 32'h9);
        gap(2);

        // Capture on the exact stale cycle keeps the position valid
        cap = cyc + 1 + SETTLE + 3;
        dwell(mkseg(7'h6F, 1'b0), an_of(3), 25);
        gap(2);
        while (cyc < cap + STALE - SETTLE - 4) tick(mkseg(7'h66, 1'b0), an_of(0));
        while (cyc < cap + STALE - 1) tick(mkseg(7'h6F, 1'b0), an_of(3));
        check("coincide_before", 32'(bus.digit_valid[3]), 32'h1);
        tick(mkseg(7'h6F, 1'b0), an_of(3));
        check("coincide_update", 32'(bus.update), 32'h1);
        check("coincide_idx", 32'(bus.update_idx), 32'd3);
        check("coincide_valid", 32'(bus.digit_valid[3]), 32'h1);
        gap(2);

        // Random dwells, gaps, bad patterns and multi-low anodes
        repeat (60) begin
            rp = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) rraw = 7'($urandom);
            else                           rraw = seg_tab[$urandom_range(0, 15)];
            if ($urandom_range(0, 9) == 0) ran = 4'($urandom);
            else                           ran = an_of(rp);
            rseg = mkseg(rraw, 1'($urandom_range(0, 1)));
            dwell(rseg, ran, $urandom_range(4, 45));
            if ($urandom_range(0, 3) == 0) begin
                dwell(rseg ^ 8'(1 << $urandom_range(0, 7)), ran, $urandom_range(1, 4));
                dwell(rseg, ran, $urandom_range(4, 30));
            end
            gap($urandom_range(0, 3));
        end
        gap(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_bus_reader.md
Name: seg_bus_reader

Overview:
- Observer/decoder for the multiplexed active-low seven-segment display bus: segment lines plus anode lines.
- Samples the bus, waits for each anode dwell to settle, and decodes the segment pattern back to a 4-bit hex digit and decimal-point state per digit position.
- Sits beside the display driver. Used for self-check, readback to the host interface, and simulation scoreboarding of displayed values.

Parameters:
- SETTLE_CYCLES, 16, consecutive identical synchronized samples required before capture (min 1).
- STALE_CYCLES, 65536, cycles without a refresh of a digit position before its valid bit clears (min SETTLE_CYCLES+4).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- seven_seg_n  input  8  display segment bus, active low; bit7 = dp (0 = lit), bits6:0 = inverted {g,f,e,d,c,b,a}
- anode_n  input  4  digit enables, active low; bit i selects digit position i
- digits  output  16  decoded digits; position i at bits 4i+3:4i
- digit_valid  output  4  bit i set when position i holds a decoded, non-stale value
- dp  output  4  bit i = decimal point lit at last capture of position i
- update  output  1  one-cycle pulse on every capture (valid or not)
- update_idx  output  2  position of the current capture; meaningful only while update=1
- decode_err  output  1  one-cycle pulse when a captured pattern is not in the decode table (blank included)

Behaviour:
- Reset: all outputs 0. Sync flops reset to all-ones (bus inactive). FSM goes to IDLE. Counters go to 0. Effect is immediate on rst_n low, mid-operation included.
- Input path: two-flop synchronizer on all 12 inputs, then one sample register (prev). stable_cnt clears when sync≠prev, otherwise increments, saturating at SETTLE_CYCLES.
- Decode table, raw = ~seven_seg_n[6:0] (gfedcba): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F. Any other raw, including 00 (blank), is an error.
- FSM:
  - IDLE: waits for synced anode_n to have exactly one bit low; then goes to SETTLE.
  - SETTLE:
    - Any sample change, or anode no longer one-hot-low, returns to IDLE (or restarts SETTLE if the new anode is one-hot-low).
    - When stable_cnt reaches SETTLE_CYCLES, capture and go to HELD.
  - HELD: no further capture. Any change to segment or anode sample goes to SETTLE (new one-hot anode) or IDLE (otherwise).
- Capture at position i:
  - Valid pattern: digits[i] ← value, digit_valid[i] ← 1, dp[i] ← ~seven_seg_n[7], update=1, update_idx=i.
  - Invalid pattern: digits[i] unchanged, digit_valid[i] ← 0, dp[i] updated, update=1, decode_err=1.
- Latency: bus held constant from edge 0 (previous sample different) → update high during cycle SETTLE_CYCLES+3, for exactly one cycle.
- Exactly one capture per dwell. A constant bus with no anode change never re-captures.
- Staleness:
  - Per-position counter clears on capture of that position and otherwise increments.
  - On reaching STALE_CYCLES, digit_valid[i] ← 0 and the counter saturates; digits[i] and dp[i] are held.
  - Capture and stale on the same cycle for the same position: capture wins.
- Anode all-high (blanking gap) or multiple low: no capture. An in-progress settle is abandoned.
- Glitch shorter than SETTLE_CYCLES on a held dwell: forces re-settle and re-capture of the same value (update pulses again, same digits).

Test Plan:
- Reset: rst_n low mid-SETTLE → all outputs 0 immediately; after release, no update until a full settle completes.
- Single capture, SETTLE_CYCLES=16: anode_n=1110, seven_seg_n=8'hB0 (raw 4F) held from edge 0 → update=1 only in cycle 19, update_idx=0, digits[3:0]=3, digit_valid=0001, dp=0000.
- Scan of all four positions, dp lit on position 2: positions 0..3 show 1, 2, A, F with dp on position 2; dwell 40 cycles each, 2-cycle all-high gaps → digits=16'hFA21, digit_valid=1111, dp=0100, four update pulses idx 0,1,2,3, no re-capture while held.
- Blank/invalid pattern: position 1 shows raw 00, then raw 7E → decode_err and update pulse each time, digit_valid[1]=0, digits[7:4] keeps prior value.
- Short dwell/glitch: dwell of 10 cycles → no update. 3-cycle segment glitch inside a 60-cycle dwell → two updates, same value.
- Staleness with STALE_CYCLES=200: capture position 3, then drive only position 0 → digit_valid[3] clears 200 cycles after its capture; a capture coinciding with the stale cycle keeps digit_valid set.
